// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES GF(2^8) helpers, mode constants and state byte layout
package aes_pkg;

  localparam logic MC_FWD = 1'b0;
  localparam logic MC_INV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mc_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul_9(input logic [7:0] a);
    return xtime(xtime(xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mul_b(input logic [7:0] a);
    logic [7:0] x2;
    x2 = xtime(a);
    return xtime(xtime(x2)) ^ x2 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul_d(input logic [7:0] a);
    logic [7:0] x4;
    x4 = xtime(xtime(a));
    return xtime(x4) ^ x4 ^ a;
  endfunction

  function automatic logic [7:0] gf_mul_e(input logic [7:0] a);
    logic [7:0] x2;
    logic [7:0] x4;
    x2 = xtime(a);
    x4 = xtime(x2);
    return xtime(x4) ^ x4 ^ x2;
  endfunction

  // State is row-major: s(r,c) occupies bits [byte_msb(r,c) -: 8].
  function automatic int byte_msb(input int r, input int c);
    return 127 - 32 * r - 8 * c;
  endfunction

endpackage

// File: rtl/aes_mix_column_word.sv
// rtl/aes_mix_column_word.sv - combinational MixColumns / InvMixColumns on one 32-bit column
module aes_mix_column_word
  import aes_pkg::*;
#(
  parameter bit SUPPORT_INV = 1'b1
) (
  input  logic [31:0] col_in,
  input  logic        mode,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;
  logic [31:0] fwd;

  assign {a0, a1, a2, a3} = col_in;
  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  assign fwd = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                a0 ^ x1 ^ x2 ^ a2 ^ a3,
                a0 ^ a1 ^ x2 ^ x3 ^ a3,
                x0 ^ a0 ^ a1 ^ a2 ^ x3};

  if (SUPPORT_INV) begin : g_inv
    logic [31:0] inv;
    assign inv = {gf_mul_e(a0) ^ gf_mul_b(a1) ^ gf_mul_d(a2) ^ gf_mul_9(a3),
                  gf_mul_9(a0) ^ gf_mul_e(a1) ^ gf_mul_b(a2) ^ gf_mul_d(a3),
                  gf_mul_d(a0) ^ gf_mul_9(a1) ^ gf_mul_e(a2) ^ gf_mul_b(a3),
                  gf_mul_b(a0) ^ gf_mul_d(a1) ^ gf_mul_9(a2) ^ gf_mul_e(a3)};
    assign col_out = (mode == MC_INV) ? inv : fwd;
  end else begin : g_fwd
    logic unused_mode;
    assign unused_mode = mode;
    assign col_out = fwd;
  end

endmodule

// File: rtl/aes_mix_columns_iter.sv
// rtl/aes_mix_columns_iter.sv - iterative AES MixColumns engine, COLS_PER_CYCLE columns per busy cycle
module aes_mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit SUPPORT_INV    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("aes_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  mc_state_e    state_q, state_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic [127:0] data_q, data_d;
  logic         mode_q, mode_d;
  logic [31:0]  col_in  [COLS_PER_CYCLE];
  logic [31:0]  col_out [COLS_PER_CYCLE];

  // Gather the columns of the current group out of the row-major register.
  always_comb begin
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      logic [1:0]  idx;
      logic [31:0] w;
      idx = col_cnt_q + 2'(k);
      w   = '0;
      for (int r = 0; r < 4; r++) begin
        w[31 - 8 * r -: 8] = data_q[byte_msb(r, int'(idx)) -: 8];
      end
      col_in[k] = w;
    end
  end

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    aes_mix_column_word #(.SUPPORT_INV(SUPPORT_INV)) u_word (
      .col_in (col_in[k]),
      .mode   (mode_q),
      .col_out(col_out[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    data_d    = data_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d    = in_data;
          mode_d    = SUPPORT_INV ? in_mode : MC_FWD;
          col_cnt_d = '0;
          state_d   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          logic [1:0] idx;
          idx = col_cnt_q + 2'(k);
          for (int r = 0; r < 4; r++) begin
            data_d[byte_msb(r, int'(idx)) -: 8] = col_out[k][31 - 8 * r -: 8];
          end
        end
        col_cnt_d = col_cnt_q + 2'(COLS_PER_CYCLE);
        if (int'(col_cnt_q) + COLS_PER_CYCLE == 4) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign out_data = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_cnt_q <= '0;
      data_q    <= '0;
      mode_q    <= MC_FWD;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
      mode_q    <= mode_d;
    end
  end

endmodule

// File: tb/tb_aes_mix_columns_iter.sv
// tb/tb_aes_mix_columns_iter.sv - directed and reference-model bench for aes_mix_columns_iter
module tb_aes_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_mode = 1'b0;
  logic [127:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         in_ready1, in_ready2, in_ready4, in_ready_ni;
  logic         out_valid1, out_valid2, out_valid4, out_valid_ni;
  logic [127:0] out_data1, out_data2, out_data4, out_data_ni;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] res1, res2, res4, res_ni;

  always #5 clk = ~clk;

  aes_mix_columns_iter #(.COLS_PER_CYCLE(1), .SUPPORT_INV(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1));
  aes_mix_columns_iter #(.COLS_PER_CYCLE(2), .SUPPORT_INV(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2));
  aes_mix_columns_iter #(.COLS_PER_CYCLE(4), .SUPPORT_INV(1'b1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4));
  aes_mix_columns_iter #(.COLS_PER_CYCLE(1), .SUPPORT_INV(1'b0)) u_dut_ni (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_ni), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid_ni), .out_ready(out_ready), .out_data(out_data_ni));

  // Column-major literal {col0,col1,col2,col3} -> row-major state.
  function automatic logic [127:0] col2state(input logic [127:0] cm);
    logic [127:0] st;
    st = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[127 - 32 * r - 8 * c -: 8] = cm[127 - 32 * c - 8 * r -: 8];
    return st;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mc(input logic [127:0] st, input logic inv);
    logic [7:0]   coef [4];
    logic [127:0] o;
    logic [7:0]   acc;
    if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - r + 4) % 4], st[127 - 32 * j - 8 * c -: 8]);
        o[127 - 32 * r - 8 * c -: 8] = acc;
      end
    return o;
  endfunction

  logic [127:0] st_a, st_b, st_c, st_d;

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [127:0] d, input logic m);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    int i;
    i = 0;
    while (!out_valid1 && i < 20) begin
      @(posedge clk);
      #1 i++;
    end
    ok = out_valid1;
  endtask

  task automatic run_block(input logic [127:0] d, input logic m);
    bit ok;
    send(d, m);
    wait_valid(ok);
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL run_block_timeout: out_valid=%0b required 1", out_valid1);
    end
    res1 = out_data1; res2 = out_data2; res4 = out_data4; res_ni = out_data_ni;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0b want 1", in_ready1); end
    n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0b want 0", out_valid1); end
    n_cmp++; if (out_data1 !== 128'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data1); end
    n_cmp++; if (out_data4 !== 128'h0) begin n_err++; $display("FAIL reset_out_data4: got %h want 0", out_data4); end
  endtask

  task automatic test_forward_latency();
    int lat1, lat2, lat4;
    lat1 = 0; lat2 = 0; lat4 = 0;
    do_reset();
    send(st_a, 1'b0);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(posedge clk);
      #1;
      if (out_valid1 && lat1 == 0) lat1 = cyc;
      if (out_valid2 && lat2 == 0) lat2 = cyc;
      if (out_valid4 && lat4 == 0) lat4 = cyc;
    end
    n_cmp++; if (lat1 != 4) begin n_err++; $display("FAIL latency_c1: got %0d want 4", lat1); end
    n_cmp++; if (lat2 != 2) begin n_err++; $display("FAIL latency_c2: got %0d want 2", lat2); end
    n_cmp++; if (lat4 != 1) begin n_err++; $display("FAIL latency_c4: got %0d want 1", lat4); end
    n_cmp++; if (out_data1 !== st_b) begin n_err++; $display("FAIL fwd_c1: got %h want %h", out_data1, st_b); end
    n_cmp++; if (out_data2 !== st_b) begin n_err++; $display("FAIL fwd_c2: got %h want %h", out_data2, st_b); end
    n_cmp++; if (out_data4 !== st_b) begin n_err++; $display("FAIL fwd_c4: got %h want %h", out_data4, st_b); end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_inverse();
    do_reset();
    run_block(st_b, 1'b1);
    n_cmp++; if (res1 !== st_a) begin n_err++; $display("FAIL inv_b_c1: got %h want %h", res1, st_a); end
    n_cmp++; if (res2 !== st_a) begin n_err++; $display("FAIL inv_b_c2: got %h want %h", res2, st_a); end
    n_cmp++; if (res4 !== st_a) begin n_err++; $display("FAIL inv_b_c4: got %h want %h", res4, st_a); end
    run_block(st_d, 1'b1);
    n_cmp++; if (res1 !== st_c) begin n_err++; $display("FAIL inv_d_c1: got %h want %h", res1, st_c); end
    n_cmp++; if (res4 !== st_c) begin n_err++; $display("FAIL inv_d_c4: got %h want %h", res4, st_c); end
    run_block(st_c, 1'b0);
    n_cmp++; if (res1 !== st_d) begin n_err++; $display("FAIL fwd_c_c1: got %h want %h", res1, st_d); end
    n_cmp++; if (res2 !== st_d) begin n_err++; $display("FAIL fwd_c_c2: got %h want %h", res2, st_d); end
  endtask

  task automatic test_no_inv();
    do_reset();
    run_block(st_a, 1'b1);
    n_cmp++; if (res_ni !== st_b) begin n_err++; $display("FAIL noinv_fwd: got %h want %h", res_ni, st_b); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    send(st_a, 1'b0);
    wait_valid(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_timeout: out_valid=%0b want 1", out_valid1); end
    in_valid = 1'b1;
    in_data  = st_c;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, out_valid1); end
      n_cmp++; if (out_data1 !== st_b) begin n_err++; $display("FAIL bp_data[%0d]: got %h want %h", i, out_data1, st_b); end
      n_cmp++; if (in_ready1 !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready1); end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %0b want 1", in_ready1); end
    n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL bp_release_valid: got %0b want 0", out_valid1); end
  endtask

  task automatic test_busy_toggle();
    do_reset();
    send(st_a, 1'b0);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      in_mode  = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_cmp++; if (out_valid1 !== 1'b1) begin n_err++; $display("FAIL toggle_valid: got %0b want 1", out_valid1); end
    n_cmp++; if (out_data1 !== st_b) begin n_err++; $display("FAIL toggle_data_c1: got %h want %h", out_data1, st_b); end
    n_cmp++; if (out_data4 !== st_b) begin n_err++; $display("FAIL toggle_data_c4: got %h want %h", out_data4, st_b); end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      n_err++; $display("FAIL toggle_extra_accept: valid=%0b ready=%0b want 0/1", out_valid1, in_ready1);
    end
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    send(st_a, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (out_valid1 !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %0b want 0", out_valid1); end
    n_cmp++; if (in_ready1 !== 1'b1) begin n_err++; $display("FAIL midrst_ready: got %0b want 1", in_ready1); end
    n_cmp++; if (out_data1 !== 128'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", out_data1); end
    run_block(st_c, 1'b0);
    n_cmp++; if (res1 !== st_d) begin n_err++; $display("FAIL midrst_fresh: got %h want %h", res1, st_d); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] q[$];
    logic [127:0] exp;
    int sent, got, cyc;
    bit acc;
    do_reset();
    sent = 0; got = 0; cyc = 0;
    in_valid  = 1'b1;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    in_mode   = 1'($urandom_range(0, 1));
    out_ready = 1'b1;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      acc = in_valid && in_ready1;
      if (out_valid1 && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL b2b_unexpected: got %h with empty scoreboard", out_data1);
        end else begin
          exp = q.pop_front();
          if (out_data1 !== exp) begin n_err++; $display("FAIL b2b[%0d]: got %h want %h", got, out_data1, exp); end
        end
        got++;
      end
      if (acc) q.push_back(ref_mc(in_data, in_mode));
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc) begin
        sent++;
        if (sent < 1000) begin
          in_data = {$urandom, $urandom, $urandom, $urandom};
          in_mode = 1'($urandom_range(0, 1));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    out_ready = 1'b0;
    n_cmp++; if (got != 1000) begin n_err++; $display("FAIL b2b_count: got %0d want 1000", got); end
  endtask

  initial begin
    st_a = col2state(128'hdb135345_01010101_c6c6c6c6_d4d4d4d5);
    st_b = col2state(128'h8e4da1bc_01010101_c6c6c6c6_d5d5d7d6);
    st_c = col2state(128'hf20a225c_2d26314c_db135345_01010101);
    st_d = col2state(128'h9fdc589d_4d7ebdf8_8e4da1bc_01010101);
    test_reset();
    test_forward_latency();
    test_inverse();
    test_no_inv();
    test_backpressure();
    test_busy_toggle();
    test_reset_mid_busy();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_mix_columns_iter.md
Name: aes_mix_columns_iter

Overview:
- Iterative, parametrised AES MixColumns engine supporting forward (encrypt) and inverse (decrypt) modes.
- Processes COLS_PER_CYCLE state columns per clock under valid/ready handshakes on both sides.
- Sits between ShiftRows and AddRoundKey in the round datapath; trades area against latency when COLS_PER_CYCLE < 4.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per BUSY cycle; legal values 1, 2, 4; elaboration error otherwise.
- SUPPORT_INV, 1, 1 = inverse datapath built and in_mode honoured; 0 = in_mode ignored, forward only.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input state present.
- in_ready  out  1  block can accept a state.
- in_mode  in  1  0 = forward MixColumns, 1 = InvMixColumns; sampled with in_data.
- in_data  in  128  state; byte s(r,c) at bits [127-32r-8c -: 8], r,c in 0..3.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  128  transformed state, same byte layout as in_data.

Behaviour:
- Reset: state IDLE; col_cnt = 0; state register = 0; mode register = 0. Outputs after reset: in_ready = 1, out_valid = 0, out_data = 0.
- FSM states:
  - IDLE: in_ready = 1. On in_valid: capture in_data and in_mode (forced to 0 if SUPPORT_INV = 0), set col_cnt = 0, go to BUSY.
  - BUSY: in_ready = 0, out_valid = 0. Each cycle, columns col_cnt .. col_cnt+COLS_PER_CYCLE-1 of the register are replaced in place by their transform. col_cnt += COLS_PER_CYCLE. When the last group is written (col_cnt + COLS_PER_CYCLE == 4), go to DONE.
  - DONE: out_valid = 1; out_data = register, held stable. On out_ready, go to IDLE.
  - In DONE, in_ready = 0: no same-cycle accept.
- Latency: out_valid rises 4/COLS_PER_CYCLE cycles after the accept edge (4, 2 or 1).
- Minimum period per block: 4/COLS_PER_CYCLE + 2 cycles with out_ready held high.
- Column transform, column a0..a3 = s(0..3,c):
  - Forward: b0=2a0^3a1^a2^a3; b1=a0^2a1^3a2^a3; b2=a0^a1^2a2^3a3; b3=3a0^a1^a2^2a3.
  - Inverse: coefficient rows {0e,0b,0d,09}, rotated right by one per output row.
- GF(2^8) arithmetic:
  - Reduction polynomial 0x11b.
  - xtime operates strictly on 8 bits: (a<<1)[7:0] ^ (a[7] ? 8'h1b : 0).
  - 9 = x8^x; 0b = x8^x2^x; 0d = x8^x4^x; 0e = x8^x4^x2, built from repeated xtime.
- Inputs while busy:
  - in_valid high during BUSY/DONE is ignored; the upstream source must hold its data.
  - in_mode/in_data changes after capture do not affect the result.
- Backpressure: out_ready low in DONE holds out_valid and out_data unchanged indefinitely.
- out_data is the register directly; it is undefined only in the sense of partially transformed values while in BUSY, since out_valid = 0 there.
- rst asserted in any state, including mid-BUSY: next cycle matches reset values; the in-flight block is discarded and no output is produced.
- col_cnt is 2 bits wide and never wraps mid-block; it is cleared on every accept.

Decomposition:
- Shared package aes_pkg:
  - xtime function and gf_mul_{9,b,d,e} functions.
  - mode constants MC_FWD = 1'b0, MC_INV = 1'b1.
  - Byte-index helper for the s(r,c) layout.
- Sub-module aes_mix_column_word:
  - Combinational; in: 32-bit column plus mode; out: 32-bit column.
  - Inverse logic generated only when SUPPORT_INV = 1.
  - The top instantiates COLS_PER_CYCLE copies, muxing the column selected by col_cnt.

Test Plan:
- Forward, column 0 = db 13 53 45, other columns 01 01 01 01 / c6 c6 c6 c6 / d4 d4 d4 d5 -> columns 8e 4d a1 bc / 01 01 01 01 / c6 c6 c6 c6 / d5 d5 d7 d6. Run for COLS_PER_CYCLE = 1, 2, 4 and check out_valid latency of 4, 2 and 1 cycles respectively.
- Inverse on the previous output (in_mode = 1) -> original state returned exactly. Columns f2 0a 22 5c <-> 9f dc 58 9d and 2d 26 31 4c <-> 4d 7e bd f8 also checked both ways.
- out_ready held low 10 cycles in DONE -> out_valid and out_data stable and in_ready = 0 throughout. On release: transfer on that edge, in_ready = 1 the next cycle.
- Toggle in_valid/in_data/in_mode during BUSY -> result equals the first captured block; no extra accept occurs.
- rst pulsed mid-BUSY (COLS_PER_CYCLE = 1, after 2 columns) -> next cycle out_valid = 0, in_ready = 1, out_data = 0. A fresh block then completes correctly.
- SUPPORT_INV = 0 with in_mode = 1 on db 13 53 45 -> forward result 8e 4d a1 bc. Back-to-back random stream checked against a reference model for 1000 blocks.
